// File: rtl/bp_stream_host_pkg.sv
// Shared definitions for the host stream router: default address map,
// inbound decode result and the status channel index.
package bp_stream_host_pkg;

    localparam int default_addr_width_lp = 32;
    localparam int default_num_ch_lp     = 4;

    localparam logic [default_num_ch_lp*default_addr_width_lp-1:0] default_ch_addr_lp =
        {32'h40, 32'h30, 32'h20, 32'h10};
    localparam logic [default_addr_width_lp-1:0] default_status_addr_lp = 32'h0;

    typedef enum logic [1:0] {
        e_dec_drop,
        e_dec_ch,
        e_dec_status
    } dec_e;

    // The status channel sits one past the last endpoint channel
    function automatic int status_ch_idx(input int num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/bp_stream_host_router_out.sv
// Outbound path: arbitrates endpoint returns and the status word into a
// single-entry output register, holding it while the host is not ready.
module bp_stream_host_router_out
    import bp_stream_host_pkg::*;
#(
    parameter int num_ch_p            = 4,
    parameter int stream_data_width_p = 32
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_ch_p-1:0]                 ch_v_i,
    input  logic [num_ch_p*stream_data_width_p-1:0] ch_data_i,
    input  logic                                status_v_i,
    input  logic [stream_data_width_p-1:0]      status_data_i,
    input  logic                                stream_ready_i,
    output logic                                stream_v_o,
    output logic [stream_data_width_p-1:0]      stream_data_o,
    output logic [$clog2(num_ch_p+1)-1:0]       stream_ch_o,
    output logic [num_ch_p-1:0]                 ch_yumi_o,
    output logic                                status_yumi_o
);
    localparam int status_idx_lp = status_ch_idx(num_ch_p);
    localparam int ch_w_lp       = $clog2(num_ch_p+1);

    logic [num_ch_p:0]               reqs, grants;
    logic [ch_w_lp-1:0]              tag;
    logic                            load;
    logic [stream_data_width_p-1:0]  data_p0, data_p1;
    logic [ch_w_lp-1:0]              ch_p1;
    logic                            vld_p1;

    assign reqs = {status_v_i, ch_v_i};
    assign load = ~reset_i & (~vld_p1 | stream_ready_i) & (|reqs);

    bsg_arb_round_robin #(.width_p(num_ch_p+1)) arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (reqs),
        .grants_o (grants),
        .tag_o    (tag),
        .yumi_i   (load)
    );

    assign ch_yumi_o     = grants[num_ch_p-1:0] & {num_ch_p{load}};
    assign status_yumi_o = grants[status_idx_lp] & load;

    // Stage p0: select the winning word
    always_comb begin
        data_p0 = '0;
        for (int k = 0; k < num_ch_p; k++)
            if (grants[k]) data_p0 = ch_data_i[k*stream_data_width_p +: stream_data_width_p];
        if (grants[status_idx_lp]) data_p0 = status_data_i;
    end

    // Stage p1: output valid, cleared once the host takes the word
    always_ff @(posedge clk_i) begin
        if (reset_i)
            vld_p1 <= 1'b0;
        else if (load)
            vld_p1 <= 1'b1;
        else if (stream_ready_i)
            vld_p1 <= 1'b0;
    end

    // Payload changes only on a load, so it holds while the host stalls
    always_ff @(posedge clk_i) begin
        if (load) begin
            data_p1 <= data_p0;
            ch_p1   <= tag;
        end
    end

    assign stream_v_o    = vld_p1;
    assign stream_data_o = data_p1;
    assign stream_ch_o   = ch_p1;

endmodule

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter; the search starts at the pointer, which moves one
// past the winner whenever the grant is taken.
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         reqs_i,
    output logic [width_p-1:0]         grants_o,
    output logic [$clog2(width_p)-1:0] tag_o,
    input  logic                       yumi_i
);
    localparam int tag_w_lp = $clog2(width_p);

    logic [tag_w_lp-1:0] ptr, winner;
    int                  idx;

    // Scan from farthest to nearest so the nearest request from ptr wins
    always_comb begin
        grants_o = '0;
        winner   = ptr;
        idx      = 0;
        for (int i = width_p-1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= width_p) idx = idx - width_p;
            if (reqs_i[tag_w_lp'(idx)]) begin
                grants_o                   = '0;
                grants_o[tag_w_lp'(idx)]   = 1'b1;
                winner                     = tag_w_lp'(idx);
            end
        end
    end

    assign tag_o = winner;

    // Advance the pointer one past the accepted winner
    always_ff @(posedge clk_i) begin
        if (reset_i)
            ptr <= '0;
        else if (yumi_i)
            ptr <= (winner == tag_w_lp'(width_p-1)) ? '0 : winner + tag_w_lp'(1);
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small valid/ready FIFO; full blocks enqueue even if a dequeue is in flight.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  mem [els_p];
    logic [ptr_w_lp:0]   wptr, rptr;
    logic                enq, deq;

    assign ready_o = ~((wptr[ptr_w_lp] != rptr[ptr_w_lp])
                     && (wptr[ptr_w_lp-1:0] == rptr[ptr_w_lp-1:0]));
    assign v_o     = (wptr != rptr);
    assign data_o  = mem[rptr[ptr_w_lp-1:0]];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Read/write pointers carry a wrap bit to tell full from empty
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + (ptr_w_lp+1)'(1);
            if (deq) rptr <= rptr + (ptr_w_lp+1)'(1);
        end
    end

    // Storage is not reset; the pointers define what is valid
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr[ptr_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_stream_host_router.sv
// Host-side stream router: decodes host writes into per-channel FIFOs,
// counts dropped writes, and merges endpoint returns onto one host stream.
module bp_stream_host_router
    import bp_stream_host_pkg::*;
#(
    parameter int stream_addr_width_p = default_addr_width_lp,
    parameter int stream_data_width_p = 32,
    parameter int num_ch_p            = default_num_ch_lp,
    parameter logic [num_ch_p*stream_addr_width_p-1:0] ch_addr_p = default_ch_addr_lp,
    parameter logic [stream_addr_width_p-1:0] status_addr_p = default_status_addr_lp,
    parameter int els_p               = 2,
    parameter int drop_cnt_width_p    = 16
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    stream_v_i,
    input  logic [stream_addr_width_p-1:0]          stream_addr_i,
    input  logic [stream_data_width_p-1:0]          stream_data_i,
    output logic                                    stream_yumi_o,
    output logic                                    stream_v_o,
    output logic [stream_data_width_p-1:0]          stream_data_o,
    output logic [$clog2(num_ch_p+1)-1:0]           stream_ch_o,
    input  logic                                    stream_ready_i,
    output logic [num_ch_p-1:0]                     ch_v_o,
    output logic [num_ch_p*stream_data_width_p-1:0] ch_data_o,
    input  logic [num_ch_p-1:0]                     ch_ready_i,
    input  logic [num_ch_p-1:0]                     ch_v_i,
    input  logic [num_ch_p*stream_data_width_p-1:0] ch_data_i,
    output logic [num_ch_p-1:0]                     ch_yumi_o
);
    dec_e                        dec;
    logic [num_ch_p-1:0]         hit, fifo_ready;
    logic                        accept;
    logic                        status_pending;
    logic                        status_yumi;
    logic [drop_cnt_width_p-1:0] drop_cnt;

    function automatic logic [drop_cnt_width_p-1:0] sat_inc(
        input logic [drop_cnt_width_p-1:0] v);
        return (&v) ? v : v + drop_cnt_width_p'(1);
    endfunction

    // One-hot address decode; the lowest matching channel wins
    always_comb begin
        hit = '0;
        dec = e_dec_drop;
        for (int k = num_ch_p-1; k >= 0; k--) begin
            if (stream_addr_i == ch_addr_p[k*stream_addr_width_p +: stream_addr_width_p]) begin
                hit    = '0;
                hit[k] = 1'b1;
                dec    = e_dec_ch;
            end
        end
        if (dec == e_dec_drop && stream_addr_i == status_addr_p) dec = e_dec_status;
    end

    // Accept unless the addressed FIFO is full or a status read is outstanding
    always_comb begin
        case (dec)
            e_dec_ch:     accept = |(hit & fifo_ready);
            e_dec_status: accept = ~status_pending;
            default:      accept = 1'b1;
        endcase
    end

    assign stream_yumi_o = stream_v_i & ~reset_i & accept;

    for (genvar k = 0; k < num_ch_p; k++) begin : g_fifo
        bsg_fifo_1r1w_small #(.width_p(stream_data_width_p), .els_p(els_p)) fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (stream_v_i & ~reset_i & hit[k]),
            .ready_o (fifo_ready[k]),
            .data_i  (stream_data_i),
            .v_o     (ch_v_o[k]),
            .data_o  (ch_data_o[k*stream_data_width_p +: stream_data_width_p]),
            .yumi_i  (ch_v_o[k] & ch_ready_i[k])
        );
    end

    // Status request flag and saturating count of unmapped writes
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            status_pending <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            if (status_yumi)
                status_pending <= 1'b0;
            else if (stream_yumi_o && dec == e_dec_status)
                status_pending <= 1'b1;
            if (stream_yumi_o && dec == e_dec_drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    bp_stream_host_router_out #(
        .num_ch_p            (num_ch_p),
        .stream_data_width_p (stream_data_width_p)
    ) out (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .ch_v_i         (ch_v_i),
        .ch_data_i      (ch_data_i),
        .status_v_i     (status_pending),
        .status_data_i  (stream_data_width_p'(drop_cnt)),
        .stream_ready_i (stream_ready_i),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_ch_o    (stream_ch_o),
        .ch_yumi_o      (ch_yumi_o),
        .status_yumi_o  (status_yumi)
    );

endmodule

// File: doc/bp_stream_host_router.md
Name: bp_stream_host_router

Overview:
- Generalised host-side stream router between the host AXI-Lite bridge and N BlackParrot stream endpoints (nbf loader, mmio, debug, and so on).
- Inbound: address-decodes host writes into per-channel buffered FIFOs.
- Outbound: round-robin arbitrates channel return data onto one host stream, tagged with the source channel.
- Adds a status channel that reports dropped (unmapped) writes. This replaces the fixed two-endpoint combinational demux.

Parameters:
- stream_addr_width_p, 32, host address width.
- stream_data_width_p, 32, stream data width.
- num_ch_p, 4, number of endpoint channels (1..8).
- ch_addr_p, {32'h40,32'h30,32'h20,32'h10}, packed num_ch_p x stream_addr_width_p; channel k matches ch_addr_p[k] exactly.
- status_addr_p, 32'h0, address of the status request.
- els_p, 2, inbound FIFO depth per channel (power of 2, at least 2).
- drop_cnt_width_p, 16, width of the saturating drop counter (at most stream_data_width_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- stream_v_i  in  1  host write valid.
- stream_addr_i  in  stream_addr_width_p  host write address.
- stream_data_i  in  stream_data_width_p  host write data.
- stream_yumi_o  out  1  host write consumed this cycle.
- stream_v_o  out  1  return data valid.
- stream_data_o  out  stream_data_width_p  return data.
- stream_ch_o  out  $clog2(num_ch_p+1)  source channel; num_ch_p denotes status.
- stream_ready_i  in  1  host ready for return data.
- ch_v_o  out  num_ch_p  per-channel inbound valid.
- ch_data_o  out  num_ch_p*stream_data_width_p  per-channel inbound data.
- ch_ready_i  in  num_ch_p  endpoint ready; a transfer occurs when v&ready.
- ch_v_i  in  num_ch_p  endpoint return valid.
- ch_data_i  in  num_ch_p*stream_data_width_p  endpoint return data.
- ch_yumi_o  out  num_ch_p  endpoint return consumed.

Behaviour:
- Reset values:
  - All FIFOs empty; ch_v_o=0, stream_v_o=0, stream_yumi_o=0, ch_yumi_o=0.
  - Drop counter 0; status_pending=0; round-robin pointer grants channel 0 first.
- Inbound decode is combinational, one-hot; the lowest index wins if ch_addr_p entries collide.
- Channel hit k:
  - stream_yumi_o=1 the same cycle iff FIFO k is not full.
  - Data is visible on ch_v_o[k] the next cycle; latency is 1.
  - A full FIFO stalls the host only for that address; other channels are unaffected.
- status_addr_p hit:
  - stream_yumi_o=1 iff status_pending=0; then status_pending is set next cycle.
  - The write data is ignored.
- Unmapped address:
  - stream_yumi_o=1 immediately; the data is dropped.
  - Drop counter increments and saturates at all-ones.
- Inbound FIFOs are valid/ready on the endpoint side. A simultaneous enqueue and dequeue on a full FIFO is not allowed: full blocks the enqueue.
- Outbound path:
  - Requesters are ch_v_i[0..num_ch_p-1] plus status_pending as index num_ch_p.
  - Arbitration is round-robin; the pointer advances to one past the winner on each grant.
- Output register (single entry):
  - Loads when empty, or when stream_v_o&stream_ready_i, and some requester is valid.
  - The winner's ch_yumi_o pulses in the load cycle. A status grant clears status_pending instead.
- Return latency:
  - ch_v_i to stream_v_o is 1 cycle.
  - Full throughput is one word per cycle under continuous stream_ready_i.
- Output hold: while stream_v_o&!stream_ready_i, stream_data_o and stream_ch_o are held stable and no ch_yumi_o is asserted.
- Status word: zero-extended drop counter, sampled in the grant cycle. The counter is NOT cleared by a read.
- Simultaneous drop and status grant in the same cycle: the status word carries the pre-increment value.
- Reset mid-operation discards FIFO contents, the pending status and the output register; there is no partial state.

Decomposition:
- Package bp_stream_host_pkg: default address-map localparams and the status channel index function.
- Inbound FIFOs: instances of bsg_fifo_1r1w_small.
- Arbitration: bsg_arb_round_robin.
- Sub-module bp_stream_host_router_out: arbiter, output register and the yumi/hold logic.

Test Plan:
- Reset, then write 0xA5 to 0x20 -> yumi same cycle; next cycle ch_v_o[1]=1, ch_data_o[1]=0xA5.
- Hold ch_ready_i[0]=0 and write 3 words to 0x10 (els_p=2) -> first two yumi, third stalls; an interleaved write to 0x30 is accepted.
- Write unmapped 0x44 three times, then write to 0x0 -> stream_v_o with stream_ch_o=4 and data 3; counter stays 3 after the read.
- With drop_cnt_width_p=4, send 20 unmapped writes then a status request -> data 0xF.
- ch_v_i=4'b1111 held, stream_ready_i=1 -> stream_ch_o sequence 0,1,2,3,0 with one ch_yumi_o per cycle.
- stream_ready_i=0 for 5 cycles with ch_v_i[2]=1 and data 0x77 -> stream_data_o stable at 0x77; ch_yumi_o[2] pulses only once; reset asserted mid-hold clears stream_v_o next cycle.
